// File: rtl/execute_mdu_ctrl.sv
// execute_mdu_ctrl
//   Sequencer for the iterative RV32M multiply/divide unit in the execute stage.
//   An M-extension op is taken from the decode/execute boundary. It then runs an
//   XLEN-step radix-2 shift-add multiply or restoring divide on operand magnitudes.
//   The result is sign-corrected and held until the memory stage accepts it.
//
// Ports
//   clk_i              clock, rising edge
//   rst                synchronous reset, active-high
//   decode_vaild_i     decode stage holds a valid instruction
//   DD_mdu_en_i        current instruction is an M-extension op
//   DD_mdu_op_i        0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   DD_rs1_data_i      operand A (forwarded)
//   DD_rs2_data_i      operand B (forwarded)
//   flush_i            kill of the execute-stage instruction
//   memory_allow_in_i  memory stage can accept this cycle
//   execute_ready_o    execute result valid; pipeline may advance
//   E_mdu_valE_o       MDU result, valid while in DONE
//   mdu_busy_o         unit is BUSY or DONE
module execute_mdu_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst,
  input  logic            decode_vaild_i,
  input  logic            DD_mdu_en_i,
  input  logic [2:0]      DD_mdu_op_i,
  input  logic [XLEN-1:0] DD_rs1_data_i,
  input  logic [XLEN-1:0] DD_rs2_data_i,
  input  logic            flush_i,
  input  logic            memory_allow_in_i,
  output logic            execute_ready_o,
  output logic [XLEN-1:0] E_mdu_valE_o,
  output logic            mdu_busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  op_e               op_q, op_d, op_in;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // Multiply: {product_hi, product_lo / multiplier}. Divide: {remainder, quotient / dividend}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  // Multiplicand or divisor magnitude.
  logic [XLEN-1:0]   opb_q, opb_d;
  // neg: negate product or quotient; rneg: negate remainder.
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;

  logic              mdu_req;
  logic              sign_a, sign_b, neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, remv, result;

  assign op_in   = op_e'(DD_mdu_op_i);
  assign mdu_req = decode_vaild_i & DD_mdu_en_i;

  // Operand conditioning at start: MULHSU treats only rs1 as signed.
  always_comb begin
    sign_a   = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    sign_b   = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    neg_a    = sign_a & DD_rs1_data_i[XLEN-1];
    neg_b    = sign_b & DD_rs2_data_i[XLEN-1];
    mag_a    = neg_a ? -DD_rs1_data_i : DD_rs1_data_i;
    mag_b    = neg_b ? -DD_rs2_data_i : DD_rs2_data_i;
    div_zero = DD_mdu_op_i[2] & (DD_rs2_data_i == '0);
    div_ovf  = (op_in inside {OP_DIV, OP_REM}) & (DD_rs1_data_i == MIN_NEG) &
               (DD_rs2_data_i == '1);
  end

  // One iteration of each algorithm; subtraction is XLEN+1 bits so its MSB is the sign.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
  end

  // Sign correction from the registered magnitudes.
  always_comb begin
    prod = neg_q  ? -acc_q : acc_q;
    quot = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    remv = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = quot;
      default:                      result = remv;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    if (flush_i || !decode_vaild_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (DD_mdu_en_i) begin
            op_d   = op_in;
            neg_d  = neg_a ^ neg_b;
            rneg_d = neg_a;
            cnt_d  = CNT_W'(XLEN);
            state_d = S_BUSY;
            if (!DD_mdu_op_i[2]) begin
              acc_d = {{XLEN{1'b0}}, mag_b};
              opb_d = mag_a;
            end else begin
              acc_d = {{XLEN{1'b0}}, mag_a};
              opb_d = mag_b;
            end
            // Special divides load final values directly and skip the iteration.
            if (div_zero || div_ovf) begin
              state_d = S_DONE;
              neg_d   = 1'b0;
              rneg_d  = 1'b0;
              acc_d   = div_zero ? {DD_rs1_data_i, {XLEN{1'b1}}}
                                 : {{XLEN{1'b0}}, DD_rs1_data_i};
            end
          end
        end
        S_BUSY: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (!op_q[2]) begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
          end else begin
            acc_d = {(div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0]),
                     acc_q[XLEN-2:0], ~div_diff[XLEN]};
          end
          if (cnt_q == CNT_W'(1)) state_d = S_DONE;
        end
        S_DONE: begin
          if (memory_allow_in_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign execute_ready_o = ~mdu_req | (state_q == S_DONE);
  assign E_mdu_valE_o    = (state_q == S_DONE) ? result : '0;
  assign mdu_busy_o      = (state_q != S_IDLE);

endmodule
